dspl_ctrl_hub75: RTL and testbench

Scan/refresh controller for a 64x32 HUB75-style RGB LED matrix driven as two 64x16 halves (top and bottom) shifted in parallel. It reads 12-bit RGB444 pixels from a frame buffer with one-cycle synchronous read latency. It serialises one bit-plane at a time onto the panel's shift-register inputs, then latches, selects the row, and un-blanks for a binary-weighted on-time. This is binary code modulation, giving 16 intensity levels per colour. It sits between the frame buffer and the panel connector pins.

---
 rtl/dspl_ctrl_hub75.sv | 93 +++++++++
 tb/tb_dspl_ctrl_hub75.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dspl_ctrl_hub75.sv
// dspl_ctrl_hub75: HUB75 64x32 scan controller with 4-plane binary code modulation.
// Define DSPL_CTRL_DEADTIME_EN to insert a blanked DEADTIME state before each new row.
module dspl_ctrl_hub75 #(
    parameter int CLK_DIV  = 4,
    parameter int BASE_ON  = 32,
    parameter int DEADTIME = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] din_top,
    input  logic [11:0] din_btm,
    output logic [9:0]  r_addr,
    output logic        sclk,
    output logic        latch,
    output logic        blank,
    output logic [2:0]  dout_top,
    output logic [2:0]  dout_btm,
    output logic [3:0]  row_sel
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int TW = $clog2((BASE_ON << 3) + DEADTIME + 1);

    typedef enum logic [1:0] {SHIFT, LATCH, DEAD, DISPLAY} state_t;

    state_t        st, nxt;
    logic [PW-1:0] ph;
    logic [6:0]    col;
    logic [TW-1:0] tmr, on_last;
    logic [1:0]    b;
    logic [3:0]    row;

    assign on_last = TW'((BASE_ON << b) - 1);

    always_comb begin
        nxt = st;
        case (st)
            SHIFT:   nxt = col[6] ? LATCH : SHIFT;
`ifdef DSPL_CTRL_DEADTIME_EN
            LATCH:   nxt = (b == 2'd0) ? DEAD : DISPLAY;
            DEAD:    nxt = (tmr == TW'(DEADTIME - 1)) ? DISPLAY : DEAD;
`else
            LATCH:   nxt = DISPLAY;
`endif
            DISPLAY: nxt = (tmr == on_last) ? SHIFT : DISPLAY;
            default: nxt = SHIFT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= SHIFT;
            ph       <= '0;
            col      <= '0;
            tmr      <= '0;
            b        <= '0;
            row      <= '0;
            row_sel  <= '0;
            dout_top <= '0;
            dout_btm <= '0;
        end else begin
            st  <= nxt;
            tmr <= (nxt != st) ? '0 : tmr + 1'b1;
            // col reaching 64 marks the trailing overlap cycle that ends SHIFT
            if (st == SHIFT && !col[6]) begin
                ph <= (ph == PW'(CLK_DIV - 1)) ? '0 : ph + 1'b1;
                if (ph == PW'(CLK_DIV - 1))
                    col <= col + 1'b1;
                if (ph == PW'(1)) begin
                    dout_top <= {din_top[{2'd2, b}], din_top[{2'd1, b}], din_top[{2'd0, b}]};
                    dout_btm <= {din_btm[{2'd2, b}], din_btm[{2'd1, b}], din_btm[{2'd0, b}]};
                end
            end
            if (st == DISPLAY && nxt == SHIFT) begin
                col <= '0;
                b   <= b + 1'b1;
                if (b == 2'd3)
                    row <= row + 1'b1;
            end
`ifdef DSPL_CTRL_DEADTIME_EN
            if (st == LATCH && nxt == DEAD)
                row_sel <= row;
`else
            if (st == SHIFT && nxt == LATCH)
                row_sel <= row;
`endif
        end
    end

    assign r_addr = {row, col[6] ? 6'd63 : col[5:0]};
    assign sclk   = (st == SHIFT) && ((ph > PW'(CLK_DIV / 2)) || (ph == '0 && col != '0));
    assign latch  = (st == LATCH);
    assign blank  = (st != DISPLAY);
endmodule

// File: tb/tb_dspl_ctrl_hub75.sv
// tb_dspl_ctrl_hub75: scoreboard bench; one expected record per plane, checked at each latch and lit period.
// Even columns read A5C/3C9, odd columns their bitwise inverse, so column order and latency are visible on dout.
module tb_dspl_ctrl_hub75;
    logic        clk, rst;
    logic [11:0] din_top, din_btm;
    logic [9:0]  r_addr;
    logic        sclk, latch, blank;
    logic [2:0]  dout_top, dout_btm;
    logic [3:0]  row_sel;

    dspl_ctrl_hub75 dut (
        .clk(clk), .rst(rst), .din_top(din_top), .din_btm(din_btm), .r_addr(r_addr),
        .sclk(sclk), .latch(latch), .blank(blank), .dout_top(dout_top), .dout_btm(dout_btm),
        .row_sel(row_sel)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        din_top <= r_addr[0] ? 12'h5A3 : 12'hA5C;
        din_btm <= r_addr[0] ? 12'hC36 : 12'h3C9;
    end

    typedef struct {
        logic [3:0] rs;
        logic [9:0] ra;
        int         gap;
        int         on;
        logic [2:0] dt;
        logic [2:0] db;
    } rec_t;

    rec_t q[$];
    int passed = 0, total = 0, runs = 0;
    int         gtab[4]  = '{290, 322, 386, 514};
    int         otab[4]  = '{32, 64, 128, 256};
    logic [2:0] dtab[4]  = '{3'b010, 3'b100, 3'b011, 3'b101};
    logic [2:0] dbtab[4] = '{3'b101, 3'b100, 3'b010, 3'b011};

    task automatic check(input string nm, input longint got, input longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic push(input int n);
        rec_t r;
        r.rs  = 4'((n / 4) % 16);
        r.ra  = {4'((n / 4) % 16), 6'd63};
        r.gap = (n == 0) ? 257 : gtab[(n - 1) % 4];
        r.on  = otab[n % 4];
        r.dt  = dtab[n % 4];
        r.db  = dbtab[n % 4];
        q.push_back(r);
    endtask

    task automatic chk_rst();
        check("rst_blank", blank, 1);
        check("rst_latch", latch, 0);
        check("rst_sclk", sclk, 0);
        check("rst_dout", {dout_top, dout_btm}, 0);
        check("rst_row_sel", row_sel, 0);
        check("rst_r_addr", r_addr, 0);
    endtask

    // monitor: samples 1 time unit after each rising edge
    initial begin
        logic [5:0] pdout, held, cur, ex;
        bit psclk, hold_chk;
        int since, edges, bad, run, pend;
        rec_t r;
        {psclk, hold_chk, pdout, held} = '0;
        {since, edges, bad, run, pend} = '0;
        forever begin
            @(posedge clk);
            #1;
            cur = {dout_top, dout_btm};
            if (rst) begin
                {since, edges, bad, run, hold_chk} = '0;
            end else begin
                since++;
                if (hold_chk) begin
                    if (cur != held) bad++;
                    hold_chk = 0;
                end
                if (sclk && !psclk) begin
                    if (q.size() > 0) begin
                        ex = {q[0].dt, q[0].db};
                        if (edges % 2 == 1) ex = ~ex;
                        if (cur != ex) bad++;
                    end
                    if (pdout != cur) bad++;
                    held = cur;
                    hold_chk = 1;
                    edges++;
                end
                if (latch) begin
                    if (q.size() == 0) begin
                        check("unexpected_latch", 1, 0);
                    end else begin
                        r = q.pop_front();
                        check("row_sel", row_sel, r.rs);
                        check("r_addr_at_latch", r_addr, r.ra);
                        check("latch_gap", since, r.gap);
                        check("sclk_edges", edges, 64);
                        check("dout_data_setup_hold_errs", bad, 0);
                        pend = r.on;
                    end
                    {edges, bad, since} = '0;
                end
                if (!blank) run++;
                else if (run > 0) begin
                    check("blank_low_run", run, pend);
                    runs++;
                    run = 0;
                end
            end
            pdout = cur;
            psclk = sclk;
        end
    end

    initial begin
        int exp_addr[5] = '{0, 0, 0, 0, 1};
        rst = 1;
        repeat (3) @(posedge clk);
        #1 chk_rst();
        for (int n = 0; n < 68; n++) push(n);
        @(negedge clk) rst = 0;
        #1 check("r_addr_seq0", r_addr, exp_addr[0]);
        for (int i = 1; i < 5; i++) begin
            @(posedge clk);
            #1 check("r_addr_seq", r_addr, exp_addr[i]);
        end
        for (int i = 0; i < 30000 && runs < 68; i++) @(negedge clk);
        check("plane_runs", runs, 68);
        repeat (100) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1 chk_rst();
        q.delete();
        for (int n = 0; n < 5; n++) push(n);
        @(negedge clk) rst = 0;
        for (int i = 0; i < 3000 && runs < 73; i++) @(negedge clk);
        check("plane_runs_after_reset", runs, 73);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
